decode_mem_multi: RTL and testbench

Two-dword memory-instruction decoder for SMEM and MUBUF formats. It replaces the stall-driven single-format decoder with ready/valid handshakes on both sides, a parametrised output queue and a synchronous flush. It sits between the main decode module, which presents instruction dwords in order, and the instruction controller, which pops fully decoded memory instructions.

---
 rtl/common_pkg.sv | 37 +++
 rtl/mem_inst_fifo.sv | 79 +++++++
 rtl/decode_mem_multi.sv | 127 ++++++++++++
 tb/tb_decode_mem_multi.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types for the memory-instruction decoders: decoded instruction record,
// format tags, opcode encodings and decoder FSM states.
package common_pkg;

    typedef enum logic {
        MEM_SMEM  = 1'b0,
        MEM_MUBUF = 1'b1
    } mem_kind_e;

    typedef struct packed {
        mem_kind_e   kind;
        logic [7:0]  op;
        logic        glc;
        logic        dlc;
        logic        slc;
        logic        offen;
        logic        idxen;
        logic        lds;
        logic        tfe;
        logic [5:0]  sbase;
        logic [7:0]  sdata;
        logic [7:0]  vaddr;
        logic [4:0]  srsrc;
        logic [20:0] offset;
        logic [7:0]  soffset;
    } mem_inst_t;

    localparam logic [5:0] SMEM_ENC  = 6'b111101;
    localparam logic [5:0] MUBUF_ENC = 6'b111000;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SMEM  = 2'd1,
        ST_WAIT_MUBUF = 2'd2
    } dec_state_e;

endpackage

// File: rtl/mem_inst_fifo.sv
// Generic decoded-instruction queue with a registered head entry; occupancy is
// tracked by a level counter so the pointers can wrap freely.
module mem_inst_fifo
    import common_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = mem_inst_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output T              head,
    output logic          head_valid
);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [LW-1:0] level_next;
    logic          do_push;
    logic          do_pop;
    T              head_next;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The head register is loaded with whatever will sit at the front after
    // this edge, bypassing storage when the pushed entry becomes the front.
    always_comb begin
        rd_next    = rd_ptr + PW'(do_pop);
        level_next = level + LW'(do_push) - LW'(do_pop);
        head_next  = '0;
        if (level_next != '0) begin
            if (do_push && ((level - LW'(do_pop)) == '0))
                head_next = push_data;
            else
                head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(do_push);
            rd_ptr     <= rd_next;
            level      <= level_next;
            head       <= head_next;
            head_valid <= (level_next != '0);
        end
    end

endmodule

// File: rtl/decode_mem_multi.sv
// Two-dword SMEM/MUBUF decoder: the first dword is held, the second completes
// the record, which is queued for the instruction controller.
module decode_mem_multi
    import common_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter bit  EN_SMEM    = 1'b1,
    parameter bit  EN_MUBUF   = 1'b1,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   in_dword,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output mem_inst_t     out_inst,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic [LW-1:0] fifo_level
);

    dec_state_e state;
    mem_inst_t  hold;
    mem_inst_t  first_smem;
    mem_inst_t  first_mubuf;
    mem_inst_t  merged;
    logic [5:0] opcode;
    logic       accept;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;

    // Back-pressure only ever lands on the second dword.
    assign in_ready = !reset && !flush && ((state == ST_IDLE) || !fifo_full);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (state != ST_IDLE);
    assign pop      = out_ready && !fifo_empty;
    assign busy     = (state != ST_IDLE);
    assign opcode   = in_dword[31:26];

    always_comb begin
        first_smem       = '0;
        first_smem.kind  = MEM_SMEM;
        first_smem.sbase = in_dword[5:0];
        first_smem.sdata = {1'b0, in_dword[12:6]};
        first_smem.dlc   = in_dword[14];
        first_smem.glc   = in_dword[16];
        first_smem.op    = in_dword[25:18];

        first_mubuf        = '0;
        first_mubuf.kind   = MEM_MUBUF;
        first_mubuf.offset = {9'b0, in_dword[11:0]};
        first_mubuf.offen  = in_dword[12];
        first_mubuf.idxen  = in_dword[13];
        first_mubuf.glc    = in_dword[14];
        first_mubuf.dlc    = in_dword[15];
        first_mubuf.lds    = in_dword[16];
        first_mubuf.op     = {1'b0, in_dword[24:18]};
    end

    // The second dword is pure payload and is never opcode-checked.
    always_comb begin
        merged = hold;
        case (state)
            ST_WAIT_SMEM: begin
                merged.offset  = in_dword[20:0];
                merged.soffset = {1'b0, in_dword[31:25]};
            end
            ST_WAIT_MUBUF: begin
                merged.vaddr   = in_dword[7:0];
                merged.sdata   = in_dword[15:8];
                merged.srsrc   = in_dword[20:16];
                merged.slc     = in_dword[22];
                merged.tfe     = in_dword[23];
                merged.soffset = in_dword[31:24];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            hold  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            hold  <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (EN_SMEM && (opcode == SMEM_ENC)) begin
                        hold  <= first_smem;
                        state <= ST_WAIT_SMEM;
                    end else if (EN_MUBUF && (opcode == MUBUF_ENC)) begin
                        hold  <= first_mubuf;
                        state <= ST_WAIT_MUBUF;
                    end
                end
                default: begin
                    hold  <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (mem_inst_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_data  (merged),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level),
        .head       (out_inst),
        .head_valid (out_valid)
    );

endmodule

// File: tb/tb_decode_mem_multi.sv
// Directed bench for decode_mem_multi: a queue-based reference model is compared
// against the DUT every cycle, alongside hand-computed literal expectations.
module tb_decode_mem_multi;
    import common_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] in_dword;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    mem_inst_t   out_inst;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [2:0]  fifo_level;

    logic [31:0] in_dword2;
    logic        in_valid2;
    logic        in_ready2;
    logic        flush2;
    mem_inst_t   out_inst2;
    logic        out_valid2;
    logic        out_ready2;
    logic        busy2;
    logic [2:0]  fifo_level2;

    int checks   = 0;
    int failures = 0;

    mem_inst_t   mq[$];
    logic        m_pending;
    logic        m_mubuf;
    logic [31:0] m_d0;
    logic        m_acc;
    logic        m_pop;
    logic [7:0]  pop_log[$];
    mem_inst_t   smem_exp;
    mem_inst_t   mubuf_exp;

    decode_mem_multi #(.FIFO_DEPTH(DEPTH), .EN_SMEM(1'b1), .EN_MUBUF(1'b1)) dut (
        .clk(clk), .reset(reset), .in_dword(in_dword), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_inst(out_inst), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .fifo_level(fifo_level)
    );

    decode_mem_multi #(.FIFO_DEPTH(DEPTH), .EN_SMEM(1'b1), .EN_MUBUF(1'b0)) dut_nomubuf (
        .clk(clk), .reset(reset), .in_dword(in_dword2), .in_valid(in_valid2),
        .in_ready(in_ready2), .flush(flush2), .out_inst(out_inst2), .out_valid(out_valid2),
        .out_ready(out_ready2), .busy(busy2), .fifo_level(fifo_level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mem_inst_t model_decode(input logic is_mubuf, input logic [31:0] a,
                                               input logic [31:0] b);
        mem_inst_t r;
        r = '0;
        if (!is_mubuf) begin
            r.kind    = MEM_SMEM;
            r.sbase   = a[5:0];
            r.sdata   = 8'(a[12:6]);
            r.dlc     = a[14];
            r.glc     = a[16];
            r.op      = a[25:18];
            r.offset  = b[20:0];
            r.soffset = 8'(b[31:25]);
        end else begin
            r.kind    = MEM_MUBUF;
            r.offset  = 21'(a[11:0]);
            r.offen   = a[12];
            r.idxen   = a[13];
            r.glc     = a[14];
            r.dlc     = a[15];
            r.lds     = a[16];
            r.op      = 8'(a[24:18]);
            r.vaddr   = b[7:0];
            r.sdata   = b[15:8];
            r.srsrc   = b[20:16];
            r.slc     = b[22];
            r.tfe     = b[23];
            r.soffset = b[31:24];
        end
        return r;
    endfunction

    // Reference model: raw first dword is remembered, the record is built on completion.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_pending = 1'b0;
            m_mubuf   = 1'b0;
            m_d0      = '0;
        end else begin
            m_acc = in_valid && !flush && (!m_pending || mq.size() < DEPTH);
            m_pop = out_ready && (mq.size() != 0);
            if (flush) begin
                mq.delete();
                m_pending = 1'b0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_acc) begin
                    if (m_pending) begin
                        mq.push_back(model_decode(m_mubuf, m_d0, in_dword));
                        m_pending = 1'b0;
                    end else if (in_dword[31:26] == 6'b111101) begin
                        m_pending = 1'b1;
                        m_mubuf   = 1'b0;
                        m_d0      = in_dword;
                    end else if (in_dword[31:26] == 6'b111000) begin
                        m_pending = 1'b1;
                        m_mubuf   = 1'b1;
                        m_d0      = in_dword;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && !flush && out_valid && out_ready)
            pop_log.push_back(out_inst.op);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check_output("cyc_in_ready", 128'(in_ready),
                         128'(!flush && (!m_pending || mq.size() < DEPTH)));
            check_output("cyc_busy", 128'(busy), 128'(m_pending));
            check_output("cyc_fifo_level", 128'(fifo_level), 128'(mq.size()));
            check_output("cyc_out_valid", 128'(out_valid), 128'(mq.size() != 0));
            if (mq.size() != 0 && out_valid)
                check_output("cyc_out_inst", 128'(out_inst), 128'(mq[0]));
        end
    end

    task automatic apply_stimulus(input logic [31:0] d);
        int n;
        in_dword = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready)
            check_output("handshake_timeout", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_stimulus2(input logic [31:0] d);
        in_dword2 = d;
        in_valid2 = 1'b1;
        check_output("nomubuf_in_ready", 128'(in_ready2), 128'(1));
        @(posedge clk);
        @(negedge clk);
        #1;
        in_valid2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_dword = '0; in_valid = 1'b0; out_ready = 1'b0;
        flush2 = 1'b0; in_dword2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;

        smem_exp = '0;
        smem_exp.kind = MEM_SMEM; smem_exp.op = 8'h01; smem_exp.sbase = 6'd2;
        smem_exp.sdata = 8'd4; smem_exp.offset = 21'h10; smem_exp.soffset = 8'h1F;
        mubuf_exp = '0;
        mubuf_exp.kind = MEM_MUBUF; mubuf_exp.offset = 21'd4; mubuf_exp.offen = 1'b1;
        mubuf_exp.glc = 1'b1; mubuf_exp.vaddr = 8'd5; mubuf_exp.sdata = 8'h10;
        mubuf_exp.srsrc = 5'd3; mubuf_exp.soffset = 8'h80;

        check_output("model_smem", 128'(model_decode(1'b0, 32'hF4040102, 32'h3E000010)), 128'(smem_exp));
        check_output("model_mubuf", 128'(model_decode(1'b1, 32'hE0005004, 32'h80031005)), 128'(mubuf_exp));

        repeat (2) @(negedge clk);
        #1;
        check_output("reset_out_valid", 128'(out_valid), 128'(0));
        check_output("reset_out_inst", 128'(out_inst), 128'(0));
        check_output("reset_busy", 128'(busy), 128'(0));
        check_output("reset_level", 128'(fifo_level), 128'(0));
        check_output("reset_in_ready", 128'(in_ready), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_output("post_reset_in_ready", 128'(in_ready), 128'(1));

        $display("[TB] SMEM decode");
        out_ready = 1'b1;
        apply_stimulus(32'hF4040102);
        check_output("smem_busy", 128'(busy), 128'(1));
        apply_stimulus(32'h3E000010);
        check_output("smem_out_valid", 128'(out_valid), 128'(1));
        check_output("smem_out_inst", 128'(out_inst), 128'(smem_exp));
        @(negedge clk);
        #1;
        check_output("smem_popped", 128'(out_valid), 128'(0));

        $display("[TB] MUBUF decode");
        out_ready = 1'b0;
        apply_stimulus(32'hE0005004);
        apply_stimulus(32'h80031005);
        check_output("mubuf_out_inst", 128'(out_inst), 128'(mubuf_exp));
        out_ready = 1'b1;
        @(negedge clk);
        #1;

        $display("[TB] non-memory dword");
        apply_stimulus(32'hBF800000);
        check_output("nonmem_busy", 128'(busy), 128'(0));
        check_output("nonmem_level", 128'(fifo_level), 128'(0));

        $display("[TB] MUBUF disabled");
        apply_stimulus2(32'hE0005004);
        check_output("nomubuf_drop_busy", 128'(busy2), 128'(0));
        apply_stimulus2(32'hF4040102);
        check_output("nomubuf_smem_busy", 128'(busy2), 128'(1));
        apply_stimulus2(32'h3E000010);
        check_output("nomubuf_out_valid", 128'(out_valid2), 128'(1));
        check_output("nomubuf_out_inst", 128'(out_inst2), 128'(smem_exp));

        $display("[TB] queue full back-pressure");
        out_ready = 1'b0;
        pop_log.delete();
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(32'hF4000000 | (32'(i) << 18));
            apply_stimulus(32'(i));
        end
        check_output("full_level", 128'(fifo_level), 128'(4));
        apply_stimulus(32'hF4000000 | (32'd5 << 18));
        in_dword = 32'd5;
        in_valid = 1'b1;
        check_output("full_in_ready", 128'(in_ready), 128'(0));
        check_output("full_busy", 128'(busy), 128'(1));
        @(negedge clk);
        #1;
        check_output("full_in_ready_held", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        apply_stimulus(32'd5);
        for (int n = 0; n < 20 && (out_valid || fifo_level != 0); n++) begin
            @(negedge clk);
            #1;
        end
        check_output("drain_level", 128'(fifo_level), 128'(0));
        check_output("pop_count", 128'(pop_log.size()), 128'(5));
        for (int i = 0; i < 5; i++)
            check_output($sformatf("order%0d", i), 128'(pop_log[i]), 128'(i + 1));

        $display("[TB] flush in WAIT_SMEM");
        out_ready = 1'b0;
        apply_stimulus(32'hF4000000 | (32'd6 << 18));
        apply_stimulus(32'd6);
        apply_stimulus(32'hF4000000 | (32'd7 << 18));
        apply_stimulus(32'd7);
        apply_stimulus(32'hF4000000 | (32'd8 << 18));
        check_output("preflush_level", 128'(fifo_level), 128'(2));
        check_output("preflush_busy", 128'(busy), 128'(1));
        out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        #1;
        check_output("flush_level", 128'(fifo_level), 128'(0));
        check_output("flush_out_valid", 128'(out_valid), 128'(0));
        check_output("flush_busy", 128'(busy), 128'(0));
        flush = 1'b0;
        @(negedge clk);
        #1;

        $display("[TB] async reset mid-instruction");
        out_ready = 1'b0;
        apply_stimulus(32'hF4000000 | (32'd9 << 18));
        apply_stimulus(32'd9);
        apply_stimulus(32'hF4040102);
        check_output("prereset_busy", 128'(busy), 128'(1));
        #1;
        reset = 1'b1;
        #1;
        check_output("async_out_valid", 128'(out_valid), 128'(0));
        check_output("async_level", 128'(fifo_level), 128'(0));
        check_output("async_busy", 128'(busy), 128'(0));
        check_output("async_in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        apply_stimulus(32'h3E000010);
        check_output("stale_d1_busy", 128'(busy), 128'(0));
        check_output("stale_d1_level", 128'(fifo_level), 128'(0));
        apply_stimulus(32'hF4040102);
        apply_stimulus(32'h3E000010);
        check_output("post_reset_out_inst", 128'(out_inst), 128'(smem_exp));
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
